// File: rtl/ai_pkg.sv
// ai_pkg: shared AI-car state encoding, lane geometry and car sprite size
// Contents: ai_state_t FSM encoding, lane geometry (LANE0_X, LANE_PITCH, NUM_LANES),
//           car sprite size (CAR_W x CAR_H) shared with the plotters, laneOrigin helper
package ai_pkg;
    typedef enum logic [2:0] {IDLE, SPAWN, DRIVE, LANE_CHANGE, CRASH} ai_state_t;
    localparam int LANE0_X = 200;
    localparam int LANE_PITCH = 80;
    localparam int NUM_LANES = 3;
    localparam int CAR_W = 47;
    localparam int CAR_H = 65;
    function automatic logic [9:0] laneOrigin(input logic [1:0] laneIdx, input int x0, input int pitch);
        return 10'(x0 + pitch * int'(laneIdx));
    endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the frame strobe into clk and emits a one-clk tick per rising edge
// Ports: clk, Reset (async, active-high), frame_clk (async strobe) -> tick (1 clk, 3 clk after edge)
module frame_tick_sync (
    input  logic clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic sync1, sync2, syncPrev;
    always_ff @(posedge clk or posedge Reset)
        if (Reset) {sync1, sync2, syncPrev} <= '0;
        else {sync1, sync2, syncPrev} <= {frame_clk, sync1, sync2};
    assign tick = sync2 & ~syncPrev;
endmodule

// File: rtl/ai_car_controller.sv
// ai_car_controller: per-frame AI car position generator (spawn, drive, lane change, crash, respawn)
// Inputs:  clk, Reset (async, active-high), frame_clk (frame strobe), start (game running),
//          collide (sprite overlap on current pixel), player_speed (rows/frame road scroll)
// Outputs: AIX/AIY (car origin), ai_active (draw car), crash_pulse (1 clk on crash entry),
//          lane (current or target lane)
module ai_car_controller
    import ai_pkg::*;
#(
    parameter int LANE0_X = ai_pkg::LANE0_X,
    parameter int LANE_PITCH = ai_pkg::LANE_PITCH,
    parameter int NUM_LANES = ai_pkg::NUM_LANES,
    parameter int LANE_STEP = 4,
    parameter int Y_LIMIT = 480,
    parameter int CHANGE_PERIOD = 32,
    parameter int CRASH_FRAMES = 60,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       collide,
    input  logic [3:0] player_speed,
    output logic [9:0] AIX,
    output logic [9:0] AIY,
    output logic       ai_active,
    output logic       crash_pulse,
    output logic [1:0] lane
);
    localparam int FC_W = $clog2(CHANGE_PERIOD + 1);
    localparam int CC_W = $clog2(CRASH_FRAMES + 1);
    ai_state_t state, stateNext;
    logic tick;
    logic [7:0] lfsr, lfsrNext;
    logic [FC_W-1:0] frameCnt, frameCntNext;
    logic [CC_W-1:0] crashCnt, crashCntNext;
    logic [9:0] aixNext, aiyNext, targetX, stepX;
    logic [10:0] ySum;
    logic offScreen, activeNext, pulseNext;
    logic [1:0] laneNext, spawnLane, decLane;

    frame_tick_sync tickSync (
        .clk(clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .tick(tick)
    );

    // The 11-bit sum keeps the off-screen compare free of 10-bit wrap-around
    assign ySum = {1'b0, AIY} + {7'd0, player_speed};
    assign offScreen = ySum >= 11'(Y_LIMIT);
    assign targetX = laneOrigin(lane, LANE0_X, LANE_PITCH);
    assign stepX = (AIX < targetX) ? AIX + 10'(LANE_STEP) : AIX - 10'(LANE_STEP);
    assign spawnLane = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
    // lfsr[1] prefers moving left; the edge lanes bounce back inward
    assign decLane = (lfsr[1] && lane != 2'd0) ? lane - 2'd1 :
                     (lane < 2'(NUM_LANES - 1)) ? lane + 2'd1 : lane - 2'd1;
    // Fibonacci taps 8,6,5,4; advances once per frame regardless of state
    assign lfsrNext = tick ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;

    always_comb begin
        stateNext = state;
        aixNext = AIX;
        aiyNext = AIY;
        laneNext = lane;
        activeNext = ai_active;
        pulseNext = 1'b0;
        frameCntNext = frameCnt;
        crashCntNext = crashCnt;
        if (!start) begin
            stateNext = IDLE;
            activeNext = 1'b0;
        end else if (collide && ai_active && (state == DRIVE || state == LANE_CHANGE)) begin
            stateNext = CRASH;
            pulseNext = 1'b1;
            crashCntNext = CC_W'(CRASH_FRAMES);
        end else begin
            case (state)
                IDLE: stateNext = SPAWN;
                SPAWN: begin
                    laneNext = spawnLane;
                    aixNext = laneOrigin(spawnLane, LANE0_X, LANE_PITCH);
                    aiyNext = '0;
                    activeNext = 1'b1;
                    frameCntNext = '0;
                    stateNext = DRIVE;
                end
                DRIVE: if (tick) begin
                    if (offScreen) begin
                        activeNext = 1'b0;
                        stateNext = SPAWN;
                    end else begin
                        aiyNext = ySum[9:0];
                        frameCntNext = frameCnt + 1'b1;
                        if (frameCnt == FC_W'(CHANGE_PERIOD - 1)) begin
                            frameCntNext = '0;
                            if (lfsr[0]) begin
                                laneNext = decLane;
                                stateNext = LANE_CHANGE;
                            end
                        end
                    end
                end
                LANE_CHANGE: if (tick) begin
                    if (offScreen) begin
                        activeNext = 1'b0;
                        stateNext = SPAWN;
                    end else begin
                        aiyNext = ySum[9:0];
                        aixNext = stepX;
                        stateNext = (stepX == targetX) ? DRIVE : LANE_CHANGE;
                    end
                end
                CRASH: if (tick) begin
                    crashCntNext = (crashCnt <= CC_W'(1)) ? '0 : crashCnt - 1'b1;
                    stateNext = (crashCnt <= CC_W'(1)) ? SPAWN : CRASH;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset)
        if (Reset) begin
            state <= IDLE;
            AIX <= 10'(LANE0_X + LANE_PITCH);
            AIY <= '0;
            lane <= 2'd1;
            ai_active <= 1'b0;
            crash_pulse <= 1'b0;
            lfsr <= LFSR_SEED;
            frameCnt <= '0;
            crashCnt <= '0;
        end else begin
            state <= stateNext;
            AIX <= aixNext;
            AIY <= aiyNext;
            lane <= laneNext;
            ai_active <= activeNext;
            crash_pulse <= pulseNext;
            lfsr <= lfsrNext;
            frameCnt <= frameCntNext;
            crashCnt <= crashCntNext;
        end
endmodule

// File: tb/tb_ai_car_controller.sv
// tb_ai_car_controller: directed scoreboard bench for ai_car_controller
module tb_ai_car_controller;
    logic clk = 1'b0;
    logic Reset, frame_clk, start, collide;
    logic [3:0] player_speed;
    logic [9:0] AIX, AIY;
    logic ai_active, crash_pulse;
    logic [1:0] lane;

    ai_car_controller dut (
        .clk(clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .start(start),
        .collide(collide),
        .player_speed(player_speed),
        .AIX(AIX),
        .AIY(AIY),
        .ai_active(ai_active),
        .crash_pulse(crash_pulse),
        .lane(lane)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_SPAWN = 1, M_DRIVE = 2, M_LC = 3, M_CRASH = 4;
    typedef struct {int x; int y; int ln; int act;} exp_t;
    exp_t sbq[$];
    int total = 0, bad = 0;
    int mState, mx, my, mLane, mAct, mFcnt, mCcnt;
    logic [7:0] mLfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    function automatic void modelReset();
        mState = M_IDLE; mx = 280; my = 0; mLane = 1; mAct = 0;
        mFcnt = 0; mCcnt = 0; mLfsr = 8'hA5;
    endfunction

    function automatic void push();
        sbq.push_back('{mx, my, mLane, mAct});
    endfunction

    function automatic void modelSpawn();
        mLane = (mLfsr[1:0] == 2'd3) ? 1 : int'(mLfsr[1:0]);
        mx = 200 + 80 * mLane; my = 0; mAct = 1; mFcnt = 0; mState = M_DRIVE;
    endfunction

    function automatic void modelTick();
        logic [7:0] old;
        int sum, tgt;
        old = mLfsr;
        mLfsr = {old[6:0], old[7] ^ old[5] ^ old[4] ^ old[3]};
        sum = my + int'(player_speed);
        if (mState == M_DRIVE || mState == M_LC) begin
            if (sum >= 480) begin
                mAct = 0; mState = M_SPAWN;
            end else if (mState == M_DRIVE) begin
                my = sum;
                mFcnt++;
                if (mFcnt == 32) begin
                    mFcnt = 0;
                    if (old[0]) begin
                        if (old[1] && mLane > 0) mLane--;
                        else if (mLane < 2) mLane++;
                        else mLane--;
                        mState = M_LC;
                    end
                end
            end else begin
                my = sum;
                tgt = 200 + 80 * mLane;
                mx = (mx < tgt) ? mx + 4 : mx - 4;
                if (mx == tgt) mState = M_DRIVE;
            end
        end else if (mState == M_CRASH) begin
            mCcnt--;
            if (mCcnt == 0) mState = M_SPAWN;
        end
    endfunction

    task automatic popCheck(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            total++; bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_x"}, AIX, e.x);
            chk({tag, "_y"}, AIY, e.y);
            chk({tag, "_lane"}, lane, e.ln);
            chk({tag, "_active"}, ai_active, e.act);
        end
    endtask

    task automatic frameEdge(input bit latChk);
        int prevY;
        bit spawnPending;
        @(negedge clk);
        frame_clk = 1'b1;
        prevY = my;
        modelTick();
        push();
        spawnPending = (mState == M_SPAWN);
        if (spawnPending) begin
            modelSpawn();
            push();
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        if (latChk) chk("latency_y", AIY, prevY);
        @(posedge clk);
        #1 popCheck("tick");
        if (spawnPending) begin
            @(posedge clk);
            #1 popCheck("spawn");
        end
        @(negedge clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic startGame(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chk({tag, "_spawn_state_inactive"}, ai_active, 0);
        @(posedge clk);
        modelSpawn();
        push();
        #1 popCheck(tag);
    endtask

    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2 Reset = 1'b1;
        start = 1'b0;
        #1;
        chk({tag, "_x"}, AIX, 280);
        chk({tag, "_y"}, AIY, 0);
        chk({tag, "_lane"}, lane, 1);
        chk({tag, "_active"}, ai_active, 0);
        chk({tag, "_pulse"}, crash_pulse, 0);
        modelReset();
        sbq.delete();
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic findLaneChange(output bit found, output int oldLane);
        found = 1'b0;
        oldLane = mLane;
        for (int i = 0; i < 400 && !found; i++) begin
            oldLane = mLane;
            frameEdge(0);
            found = (mState == M_LC);
        end
        if (!found) begin
            total++; bad++;
            $error("FAIL lc_search observed=no_lane_change expected=lane_change_within_400_ticks");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int oldLane, px, dx, steps;
        Reset = 1'b0; frame_clk = 1'b0; start = 1'b0; collide = 1'b0; player_speed = 4'd0;
        modelReset();
        #3 Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_x", AIX, 280);
        chk("rst_y", AIY, 0);
        chk("rst_lane", lane, 1);
        chk("rst_active", ai_active, 0);
        chk("rst_pulse", crash_pulse, 0);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold_x", AIX, 280);

        startGame("start");
        chk("start_x_const", AIX, 280);
        chk("start_lane_const", lane, 1);

        player_speed = 4'd5;
        for (int i = 1; i <= 10; i++) frameEdge(1);
        chk("ten_ticks_y", AIY, 50);
        chk("ten_ticks_x", AIX, 280);

        for (int i = 11; i <= 96; i++) begin
            frameEdge(0);
            if (i == 95) chk("tick95_y", AIY, 475);
        end
        chk("respawn_y", AIY, 0);
        chk("respawn_active", ai_active, 1);

        player_speed = 4'd1;
        findLaneChange(found, oldLane);
        if (found) begin
            dx = int'(lane) - oldLane;
            chk("lc_lane_delta", (dx < 0) ? -dx : dx, 1);
            steps = 0;
            while (mState == M_LC && steps < 25) begin
                px = int'(AIX);
                frameEdge(0);
                dx = int'(AIX) - px;
                chk("lc_step", (dx < 0) ? -dx : dx, 4);
                steps++;
            end
            chk("lc_ticks", steps, 20);
            chk("lc_target", AIX, 200 + 80 * int'(lane));
        end

        findLaneChange(found, oldLane);
        if (found) begin
            repeat (3) frameEdge(0);
            chk("lc_mid_x_off_grid", (int'(AIX) - 200) % 80 != 0, 1);
        end
        asyncReset("rst_mid_lc");

        startGame("crash_start");
        player_speed = 4'd5;
        repeat (20) frameEdge(0);
        chk("crash_pre_y", AIY, 100);
        @(negedge clk);
        collide = 1'b1;
        @(posedge clk);
        #1 chk("crash_pulse_on", crash_pulse, 1);
        mState = M_CRASH;
        mCcnt = 60;
        @(negedge clk);
        collide = 1'b0;
        @(posedge clk);
        #1 chk("crash_pulse_off", crash_pulse, 0);
        for (int i = 1; i <= 60; i++) begin
            if (i == 30) begin
                @(negedge clk);
                collide = 1'b1;
                @(posedge clk);
                #1 chk("crash_no_retrigger", crash_pulse, 0);
                @(negedge clk);
                collide = 1'b0;
            end
            frameEdge(0);
            if (i < 60) begin
                chk("crash_hold_y", AIY, 100);
                chk("crash_hold_active", ai_active, 1);
            end
        end
        chk("crash_respawn_y", AIY, 0);

        repeat (5) frameEdge(0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        mState = M_IDLE;
        mAct = 0;
        push();
        #1 popCheck("start_drop");
        chk("start_drop_y", AIY, 25);
        frameEdge(0);
        startGame("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
